// File: rtl/led_breather_pkg.sv
// Shared types and default widths for the LED breathing envelope driver.
// The phase encoding is also what the phase output presents.
package led_breather_pkg;

  localparam int unsigned DEF_N      = 8;
  localparam int unsigned DEF_HOLD_W = 8;

  typedef enum logic [1:0] {
    RISING    = 2'd0,
    HOLD_HIGH = 2'd1,
    FALLING   = 2'd2,
    HOLD_LOW  = 2'd3
  } breather_phase_t;

endpackage

// File: rtl/led_breather_pwm.sv
// Free-running PWM counter with a registered duty compare.
// Disabled: the counter freezes and the output is forced low.
module pwm #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [N-1:0] duty,
  output logic         out
);

  logic [N-1:0] cnt_q, cnt_d;
  logic         out_q, out_d;

  always_comb begin
    cnt_d = cnt_q;
    out_d = 1'b0;
    if (ena) begin
      cnt_d = cnt_q + N'(1);
      out_d = (cnt_q < duty);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/led_breather.sv
// Triangle-envelope PWM driver: each step pulse walks the duty through
// rise, hold-high, fall and hold-low; the pwm block turns duty into a pin.
module led_breather
  import led_breather_pkg::*;
#(
  parameter int unsigned N      = DEF_N,
  parameter int unsigned HOLD_W = DEF_HOLD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              step,
  input  logic [N-1:0]      duty_max,
  input  logic [HOLD_W-1:0] hold_ticks,
  output logic [N-1:0]      duty,
  output logic [1:0]        phase,
  output logic              pwm_out,
  output logic              cycle_done
);

  breather_phase_t   phase_q, phase_d;
  logic [N-1:0]      duty_q, duty_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              done_q, done_d;

  logic              adv;
  logic [N:0]        duty_inc;
  logic              at_peak;
  logic              at_floor;
  logic              hold_zero;

  assign adv       = ena && step;
  // One extra bit so duty_max = 2^N-1 never wraps the increment.
  assign duty_inc  = {1'b0, duty_q} + (N+1)'(1);
  assign at_peak   = duty_inc >= {1'b0, duty_max};
  assign at_floor  = duty_q <= N'(1);
  assign hold_zero = hold_q == '0;

  always_comb begin
    phase_d = phase_q;
    duty_d  = duty_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    if (adv) begin
      unique case (phase_q)
        RISING: begin
          if (at_peak) begin
            duty_d  = duty_max;
            hold_d  = hold_ticks;
            phase_d = HOLD_HIGH;
          end else begin
            duty_d  = duty_inc[N-1:0];
          end
        end
        HOLD_HIGH: begin
          if (hold_zero) begin
            phase_d = FALLING;
          end else begin
            hold_d  = hold_q - HOLD_W'(1);
          end
        end
        FALLING: begin
          if (at_floor) begin
            duty_d  = '0;
            hold_d  = hold_ticks;
            phase_d = HOLD_LOW;
          end else begin
            duty_d  = duty_q - N'(1);
          end
        end
        HOLD_LOW: begin
          if (hold_zero) begin
            phase_d = RISING;
            done_d  = 1'b1;
          end else begin
            hold_d  = hold_q - HOLD_W'(1);
          end
        end
        default: phase_d = RISING;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= RISING;
      duty_q  <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      duty_q  <= duty_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
    end
  end

  pwm #(
    .N(N)
  ) u_pwm (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .duty(duty_q),
    .out (pwm_out)
  );

  assign duty       = duty_q;
  assign phase      = phase_q;
  assign cycle_done = done_q;

endmodule

// File: tb/tb_led_breather.sv
// Self-checking bench for led_breather against a per-envelope
// expected-sequence model built from the phase rules.
module tb_led_breather;
  import led_breather_pkg::*;

  localparam int N  = 8;
  localparam int HW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          ena;
  logic          step;
  logic [N-1:0]  duty_max;
  logic [HW-1:0] hold_ticks;
  logic [N-1:0]  duty;
  logic [1:0]    phase;
  logic          pwm_out;
  logic          cycle_done;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int d;
    int p;
    bit done;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  led_breather #(.N(N), .HOLD_W(HW)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .step      (step),
    .duty_max  (duty_max),
    .hold_ticks(hold_ticks),
    .duty      (duty),
    .phase     (phase),
    .pwm_out   (pwm_out),
    .cycle_done(cycle_done)
  );

  function automatic void push(int d, int p, bit done);
    exp_t e;
    e.d = d;
    e.p = p;
    e.done = done;
    q.push_back(e);
  endfunction

  // Expected outputs after each step of one full envelope from RISING/0.
  function automatic void build_env(int dm, int h);
    q.delete();
    if (dm == 0) push(0, 1, 0);
    else for (int v = 1; v <= dm; v++) push(v, (v == dm) ? 1 : 0, 0);
    for (int i = 0; i <= h; i++) push(dm, (i == h) ? 2 : 1, 0);
    if (dm == 0) push(0, 3, 0);
    else for (int v = dm - 1; v >= 0; v--) push(v, (v == 0) ? 3 : 2, 0);
    for (int i = 0; i <= h; i++) push(0, (i == h) ? 0 : 3, i == h);
  endfunction

  task automatic pulse();
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    ena = 1'b1;
    step = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ena = 1'b1;
    duty_max = 8'd5;
    hold_ticks = 8'd1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      step = i[0];
    end
    @(negedge clk);
    n_cmp++;
    if ({duty, phase, pwm_out, cycle_done} !== '0) begin
      n_bad++;
      $display("FAIL reset: duty=%0d phase=%0d pwm=%b done=%b want all 0",
               duty, phase, pwm_out, cycle_done);
    end
    step = 1'b0;
    rst = 1'b1;
  endtask

  // Walks q[from..to) one step at a time, checking each step's outputs.
  task automatic walk(string nm, int from, int to, int gmax, bit rnd_ena);
    for (int k = from; k < to; k++) begin
      pulse();
      n_cmp++;
      if (duty !== N'(q[k].d) || phase !== 2'(q[k].p) ||
          cycle_done !== q[k].done) begin
        n_bad++;
        $display("FAIL %s step%0d: duty=%0d phase=%0d done=%b want %0d %0d %b",
                 nm, k, duty, phase, cycle_done, q[k].d, q[k].p, q[k].done);
      end
      for (int g = $urandom_range(0, gmax); g > 0; g--) begin
        if (rnd_ena && $urandom_range(0, 2) == 0) begin
          ena = 1'b0;
          step = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        ena = 1'b1;
        step = 1'b0;
      end
      @(negedge clk);
      n_cmp++;
      if (duty !== N'(q[k].d) || phase !== 2'(q[k].p) || cycle_done !== 1'b0) begin
        n_bad++;
        $display("FAIL %s idle%0d: duty=%0d phase=%0d done=%b want %0d %0d 0",
                 nm, k, duty, phase, cycle_done, q[k].d, q[k].p);
      end
    end
  endtask

  task automatic test_envelope();
    duty_max = 8'd4;
    hold_ticks = 8'd1;
    build_env(4, 1);
    n_cmp++;
    if (q.size() != 12) begin
      n_bad++;
      $display("FAIL env_len: model=%0d want 12", q.size());
    end
    for (int k = 0; k < 12; k++) begin
      pulse();
      n_cmp++;
      if (duty !== N'(q[k].d) || phase !== 2'(q[k].p) ||
          cycle_done !== q[k].done) begin
        n_bad++;
        $display("FAIL env step%0d: duty=%0d phase=%0d done=%b want %0d %0d %b",
                 k, duty, phase, cycle_done, q[k].d, q[k].p, q[k].done);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    for (int e = 0; e < 6; e++) begin
      int dm = $urandom_range(0, 12);
      int h = $urandom_range(0, 3);
      duty_max = N'(dm);
      hold_ticks = HW'(h);
      build_env(dm, h);
      walk("rand", 0, q.size(), 3, 1'b1);
    end
  endtask

  task automatic test_pwm();
    int hi;
    int dvals[3] = '{64, 255, 0};
    for (int t = 0; t < 3; t++) begin
      do_reset();
      duty_max = N'(dvals[t]);
      hold_ticks = 8'd255;
      for (int s = 0; s < ((dvals[t] == 0) ? 1 : dvals[t]); s++) pulse();
      repeat (2) @(negedge clk);
      hi = 0;
      for (int c = 0; c < 256; c++) begin
        hi += int'(pwm_out);
        @(negedge clk);
      end
      n_cmp++;
      if (hi != dvals[t] || duty !== N'(dvals[t])) begin
        n_bad++;
        $display("FAIL pwm duty%0d: high=%0d duty=%0d want %0d",
                 dvals[t], hi, duty, dvals[t]);
      end
    end
  endtask

  task automatic test_freeze();
    do_reset();
    duty_max = 8'd10;
    hold_ticks = 8'd0;
    build_env(10, 0);
    walk("frz_pre", 0, 15, 0, 1'b0);
    ena = 1'b0;
    for (int c = 0; c < 50; c++) begin
      step = c[0];
      @(negedge clk);
      n_cmp++;
      if (duty !== 8'd6 || phase !== 2'd2 || pwm_out !== 1'b0 ||
          cycle_done !== 1'b0) begin
        n_bad++;
        $display("FAIL freeze c%0d: duty=%0d phase=%0d pwm=%b done=%b want 6 2 0 0",
                 c, duty, phase, pwm_out, cycle_done);
      end
    end
    ena = 1'b1;
    step = 1'b0;
    walk("frz_post", 15, q.size(), 1, 1'b0);
  endtask

  task automatic test_peak_lower();
    do_reset();
    duty_max = 8'd10;
    hold_ticks = 8'd2;
    repeat (6) pulse();
    n_cmp++;
    if (duty !== 8'd6 || phase !== 2'd0) begin
      n_bad++;
      $display("FAIL peak_pre: duty=%0d phase=%0d want 6 0", duty, phase);
    end
    duty_max = 8'd3;
    pulse();
    n_cmp++;
    if (duty !== 8'd3 || phase !== 2'd1) begin
      n_bad++;
      $display("FAIL peak_low: duty=%0d phase=%0d want 3 1", duty, phase);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    duty_max = 8'd3;
    hold_ticks = 8'd5;
    repeat (4) pulse();
    n_cmp++;
    if (duty !== 8'd3 || phase !== 2'd1) begin
      n_bad++;
      $display("FAIL rmid_pre: duty=%0d phase=%0d want 3 1", duty, phase);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({duty, phase, pwm_out, cycle_done} !== '0) begin
      n_bad++;
      $display("FAIL rmid_async: duty=%0d phase=%0d pwm=%b done=%b want all 0",
               duty, phase, pwm_out, cycle_done);
    end
    @(negedge clk);
    rst = 1'b1;
    pulse();
    n_cmp++;
    if (duty !== 8'd1 || phase !== 2'd0) begin
      n_bad++;
      $display("FAIL rmid_post: duty=%0d phase=%0d want 1 0", duty, phase);
    end
  endtask

  initial begin
    rst = 1'b0;
    ena = 1'b0;
    step = 1'b0;
    duty_max = '0;
    hold_ticks = '0;
    test_reset();
    test_envelope();
    test_random();
    test_pwm();
    test_freeze();
    test_peak_lower();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_breather.md
# led_breather

Triangle-envelope PWM driver that consumes the one-cycle `step` pulses produced by the team's pulse generator. Each `step` advances a duty-cycle envelope through rise, hold-high, fall and hold-low phases. An internal free-running PWM counter turns the current duty into a pin-level `pwm_out`. It sits between the pulse generator (rate control) and the board LED/output pin.

## Interface

**Parameters**
- `N`, 8: duty and PWM counter width; PWM period is 2^N clocks.
- `HOLD_W`, 8: width of `hold_ticks` and the internal hold counter.

**Ports**
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `ena`  in  1  global enable; low freezes all state.
- `step`  in  1  one-cycle envelope advance pulse, driven by the pulse generator.
- `duty_max`  in  N  envelope peak.
- `hold_ticks`  in  HOLD_W  hold length; each hold phase lasts `hold_ticks+1` steps.
- `duty`  out  N  current envelope value (registered).
- `phase`  out  2  current state: RISING=0, HOLD_HIGH=1, FALLING=2, HOLD_LOW=3.
- `pwm_out`  out  1  PWM output (registered).
- `cycle_done`  out  1  one-cycle pulse at the end of each full envelope.

## Operation

- Reset values: `duty`=0, `phase`=RISING, hold counter=0, PWM counter=0, `pwm_out`=0, `cycle_done`=0.
- `ena`=0: every register holds its value except two. `pwm_out` is forced to 0 and `cycle_done` is forced to 0. `step` is ignored.
- The envelope advances only on cycles with `ena`=1 and `step`=1. Transitions by state:
  - **RISING:** if `duty+1 >= duty_max` (compare at N+1 bits), then `duty` <= `duty_max`, hold counter <= `hold_ticks`, and the state goes to HOLD_HIGH. Otherwise `duty` <= `duty+1`.
  - **HOLD_HIGH:** if the hold counter is 0, go to FALLING. Otherwise decrement the hold counter. `duty` is unchanged.
  - **FALLING:** if `duty <= 1`, then `duty` <= 0, hold counter <= `hold_ticks`, and the state goes to HOLD_LOW. Otherwise `duty` <= `duty-1`.
  - **HOLD_LOW:** if the hold counter is 0, go to RISING and assert `cycle_done` for exactly one cycle. Otherwise decrement the hold counter.
- PWM counter: N-bit, increments every cycle while `ena`=1, and wraps 2^N-1 -> 0.
- `pwm_out` <= `ena` && (PWM counter < `duty`). The compare uses the current register values.
- Duty extremes:
  - `duty`=0 gives constant low.
  - `duty`=2^N-1 gives high for 2^N-1 of every 2^N clocks.
- `duty_max`=0: RISING exits on the first step with `duty`=0.
- `duty_max` changes while running:
  - Lowered during RISING: the next step clamps `duty` to the new `duty_max` and enters HOLD_HIGH.
  - Changed during HOLD_HIGH or FALLING: no effect until the next RISING.
- `hold_ticks` is sampled only on entry to a hold phase.
- No arithmetic wraps: `duty` never exceeds max(`duty_max`, value at change) and never underflows below 0.

## Timing

- `duty`, `phase` and `cycle_done` update on the clock edge that samples `step`=1. They are visible the following cycle.
- `pwm_out` lags the `duty`/counter compare by one cycle.
- A `step` that arrives on the same cycle as a phase transition is consumed by that transition. No step is lost or double-counted.
- Envelope length is `2*duty_max + 2*(hold_ticks+1)` steps for `duty_max` >= 1.
- `cycle_done` is asserted on the same edge at which `phase` returns to RISING.
- Reset asserted mid-envelope clears all state immediately (asynchronously). After release, operation restarts at RISING with `duty`=0 on the first enabled step.

## Structure

- Package `led_breather_pkg`:
  - enum `breather_phase_t` (RISING, HOLD_HIGH, FALLING, HOLD_LOW) with the 2-bit encoding above.
  - default width constants.
- Sub-module `pwm`, with ports `clk`, `rst`, `ena`, `duty[N-1:0]` and `out`. It holds the free-running counter and the registered compare, and is instantiated once.
- Envelope FSM and hold counter live in `led_breather`.

## Test plan

- **Reset:** hold `rst`=0, toggle `clk` and `step` -> `duty`=0, `phase`=0, `pwm_out`=0, `cycle_done`=0.
- **Envelope:** `N`=8, `duty_max`=4, `hold_ticks`=1, one `step` every 3 clocks ->
  - `duty` sequence 1,2,3,4,4,4,3,2,1,0,0,0.
  - `cycle_done` pulses once, on the 12th step, and `phase` returns to 0.
- **PWM:** force `duty`=64 via steps with `duty_max`=64 -> exactly 64 high clocks per 256-clock window. `duty_max`=0 -> `pwm_out` constantly 0.
- **Enable freeze:** drop `ena` for 50 clocks mid-FALLING with `step` pulses present -> `duty`, `phase` and the hold counter are unchanged, and `pwm_out`=0. Resume continues from the same value.
- **Peak lowered:** change `duty_max` 10 -> 3 while `duty`=6 in RISING -> the next step gives `duty`=3 and `phase`=HOLD_HIGH.
- **Reset mid-operation:** assert `rst` asynchronously (between edges) during HOLD_HIGH -> outputs clear before the next clock edge. After release, the first step gives `duty`=1 in RISING.
